// File: rtl/prom_nibble_loader_if.sv
// Download-stream and PROM read-port bundle for prom_nibble_loader.
// The cksum_ok signal exists only when PROM_LOADER_CKSUM_EN is defined.
interface prom_nibble_loader_if #(
    parameter int AW = 8
);
    logic          dn_download;
    logic          dn_wr;
    logic [24:0]   dn_addr;
    logic [7:0]    dn_data;
    logic [AW-1:0] addr;
    logic          cs;
    logic [3:0]    dout;
    logic          loaded;
    logic          load_err;
    logic [8:0]    wr_count;
`ifdef PROM_LOADER_CKSUM_EN
    logic          cksum_ok;

    modport master (
        output dn_download, dn_wr, dn_addr, dn_data, addr, cs,
        input  dout, loaded, load_err, wr_count, cksum_ok
    );
    modport slave (
        input  dn_download, dn_wr, dn_addr, dn_data, addr, cs,
        output dout, loaded, load_err, wr_count, cksum_ok
    );
`else
    modport master (
        output dn_download, dn_wr, dn_addr, dn_data, addr, cs,
        input  dout, loaded, load_err, wr_count
    );
    modport slave (
        input  dn_download, dn_wr, dn_addr, dn_data, addr, cs,
        output dout, loaded, load_err, wr_count
    );
`endif
endinterface

// File: rtl/prom_nibble_loader.sv
// RAM-backed 256x4 PROM loaded from the ROM download stream, with a registered read port.
// Define PROM_LOADER_CKSUM_EN to also require the nibble sum to equal EXPECT_SUM (adds cksum_ok).
module prom_nibble_loader #(
    parameter logic [24:0] BASE_ADDR  = 25'h0,
    parameter int          DEPTH      = 256,
    parameter int          AW         = 8,
    parameter logic [11:0] EXPECT_SUM = 12'h000
) (
    input  logic                  clk,
    input  logic                  reset,
    prom_nibble_loader_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

    state_t        r_state;
    logic          r_dl_q;
    logic [8:0]    r_wr_count;
    logic [11:0]   r_sum;
    logic          r_pend_err;
    logic          r_loaded;
    logic          r_load_err;
    logic          r_cksum_ok;
    logic [3:0]    r_dout;
    logic [3:0]    r_ram [DEPTH];

    logic [24:0]   w_off;
    logic          w_in_win;
    logic [AW-1:0] w_waddr;
    logic [3:0]    w_nib;
    logic          w_rise;
    logic          w_fall;
    logic          w_wr_ok;
    logic          w_sum_ok;
    logic          w_img_ok;

    assign w_off    = bus.dn_addr - BASE_ADDR;
    assign w_in_win = (bus.dn_addr >= BASE_ADDR) && (w_off < 25'(DEPTH));
    assign w_waddr  = w_off[AW-1:0];
    assign w_nib    = bus.dn_data[3:0];
    assign w_rise   = bus.dn_download & ~r_dl_q;
    assign w_fall   = ~bus.dn_download & r_dl_q;
    assign w_wr_ok  = (r_state == S_LOAD) && bus.dn_wr && bus.dn_download && w_in_win;

`ifdef PROM_LOADER_CKSUM_EN
    assign w_sum_ok = (r_sum == EXPECT_SUM);
`else
    // The sum is still tracked but never gates completion in this build.
    assign w_sum_ok = (r_sum == EXPECT_SUM) | 1'b1;
`endif
    assign w_img_ok = (r_wr_count == 9'd256) && !r_pend_err && w_sum_ok;

    // The edge detector resets high so a download already in flight is not mistaken for a new one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_dl_q     <= 1'b1;
            r_wr_count <= 9'd0;
            r_sum      <= 12'd0;
            r_pend_err <= 1'b0;
            r_loaded   <= 1'b0;
            r_load_err <= 1'b0;
            r_cksum_ok <= 1'b0;
        end else begin
            r_dl_q <= bus.dn_download;
            case (r_state)
                S_LOAD: begin
                    if (w_fall) begin
                        if (w_img_ok) begin
                            r_state    <= S_DONE;
                            r_loaded   <= 1'b1;
                            r_cksum_ok <= 1'b1;
                        end else begin
                            r_state    <= S_ERR;
                            r_load_err <= 1'b1;
                        end
                    end else if (w_wr_ok) begin
                        if (r_wr_count != 9'd256)
                            r_wr_count <= r_wr_count + 9'd1;
                        r_sum <= r_sum + {8'h00, w_nib};
                        if (bus.dn_data[7:4] != 4'h0)
                            r_pend_err <= 1'b1;
                    end
                end
                default: begin
                    if (w_rise) begin
                        r_state    <= S_LOAD;
                        r_wr_count <= 9'd0;
                        r_sum      <= 12'd0;
                        r_pend_err <= 1'b0;
                        r_loaded   <= 1'b0;
                        r_load_err <= 1'b0;
                        r_cksum_ok <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Contents survive reset; only a completed load makes them visible.
    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_ram[w_waddr] <= w_nib;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_dout <= 4'h0;
        else if (bus.cs)
            r_dout <= r_loaded ? r_ram[bus.addr] : 4'h0;
    end

    assign bus.dout     = r_dout;
    assign bus.loaded   = r_loaded;
    assign bus.load_err = r_load_err;
    assign bus.wr_count = r_wr_count;
`ifdef PROM_LOADER_CKSUM_EN
    assign bus.cksum_ok = r_cksum_ok;
`else
    logic w_unused;
    assign w_unused = r_cksum_ok;
`endif
endmodule
